// File: rtl/program_loader_if.sv
// Byte-stream input and control-unit programmer port of the program loader.
// master = loader side, slave = UART receiver / control unit side.
interface program_loader_if #(
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int REGISTER_WIDTH       = 4
) ();
  logic                            rx_valid_i;
  logic [7:0]                      rx_data_i;
  logic                            p_active_i;
  logic                            p_programm_o;
  logic                            p_write_en_mem_o;
  logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o;
  logic [REGISTER_WIDTH-1:0]       p_data_o;

  modport master (
    input  rx_valid_i, rx_data_i, p_active_i,
    output p_programm_o, p_write_en_mem_o, p_address_o, p_data_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, p_active_i,
    input  p_programm_o, p_write_en_mem_o, p_address_o, p_data_o
  );
endinterface

// File: rtl/program_loader.sv
// Parses SYNC/count/records/checksum frames and writes nibble records through the control unit.
// Latency: write strobe one cycle after a pending record meets p_active_i; records wait while inactive.
module program_loader #(
  parameter int          MEMORY_ADDRESS_WIDTH = 4,
  parameter int          REGISTER_WIDTH       = 4,
  parameter logic [7:0]  SYNC_BYTE            = 8'hA5
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  program_loader_if.master  bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COUNT   = 3'd1;
  localparam logic [2:0] ST_RECORD  = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int         CW        = MEMORY_ADDRESS_WIDTH + 1;
  localparam logic [8:0] MAX_COUNT = 9'(2 ** MEMORY_ADDRESS_WIDTH);

  logic [2:0]    state;
  logic          pend_vld;
  logic [7:0]    pend_dat;
  logic [CW-1:0] remaining;
  logic [7:0]    checksum;
  logic          chk_seen;

  logic drain;
  logic rx_rec;
  logic rec_load;

  assign drain    = pend_vld & bus.p_active_i;
  assign rx_rec   = bus.rx_valid_i && (state == ST_RECORD) && (remaining != '0);
  // A draining entry frees the slot in the same cycle, so a simultaneous byte is not an overrun.
  assign rec_load = rx_rec && (!pend_vld || drain);
  assign busy_o   = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                <= ST_IDLE;
      pend_vld             <= 1'b0;
      pend_dat             <= '0;
      remaining            <= '0;
      checksum             <= '0;
      chk_seen             <= 1'b0;
      done_o               <= 1'b0;
      error_o              <= 1'b0;
      bus.p_programm_o     <= 1'b0;
      bus.p_write_en_mem_o <= 1'b0;
      bus.p_address_o      <= '0;
      bus.p_data_o         <= '0;
    end else begin
      done_o               <= 1'b0;
      bus.p_write_en_mem_o <= drain;
      if (drain) begin
        bus.p_address_o <= pend_dat[7 -: MEMORY_ADDRESS_WIDTH];
        bus.p_data_o    <= pend_dat[REGISTER_WIDTH-1:0];
      end

      if (rec_load) begin
        pend_vld <= 1'b1;
        pend_dat <= bus.rx_data_i;
      end else if (drain) begin
        pend_vld <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.rx_valid_i && bus.rx_data_i == SYNC_BYTE) begin
            state    <= ST_COUNT;
            error_o  <= 1'b0;
            checksum <= '0;
          end
        end
        ST_COUNT: begin
          if (bus.rx_valid_i) begin
            if (bus.rx_data_i == 8'd0 || {1'b0, bus.rx_data_i} > MAX_COUNT) begin
              error_o <= 1'b1;
              done_o  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              remaining        <= bus.rx_data_i[CW-1:0];
              bus.p_programm_o <= 1'b1;
              state            <= ST_RECORD;
            end
          end
        end
        ST_RECORD: begin
          if (bus.rx_valid_i) begin
            if (remaining != '0) begin
              checksum  <= checksum ^ bus.rx_data_i;
              remaining <= remaining - CW'(1);
              if (!rec_load) error_o <= 1'b1;
            end else begin
              // All records counted but the last write is still queued: this is the checksum.
              if (bus.rx_data_i != checksum) error_o <= 1'b1;
              chk_seen <= 1'b1;
              state    <= ST_CHECK;
            end
          end else if (remaining == '0 && !pend_vld) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!chk_seen && bus.rx_valid_i && bus.rx_data_i != checksum) error_o <= 1'b1;
          // Programming mode is held until the final queued record has been written.
          if (chk_seen || bus.rx_valid_i) begin
            if (!pend_vld) begin
              bus.p_programm_o <= 1'b0;
              chk_seen         <= 1'b0;
              state            <= ST_RELEASE;
            end else begin
              chk_seen <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (!bus.p_active_i) begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven frames, directed corner cases, random sessions.
module tb_program_loader;
  logic clk;
  logic reset_n;
  logic busy, done, error;

  program_loader_if #(.MEMORY_ADDRESS_WIDTH(4), .REGISTER_WIDTH(4)) bus ();

  program_loader #(.MEMORY_ADDRESS_WIDTH(4), .REGISTER_WIDTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] wlog [$];
  int         done_cnt  = 0;
  bit         prog_seen = 0;

  always @(negedge clk) begin
    if (bus.p_write_en_mem_o) wlog.push_back({bus.p_address_o, bus.p_data_o});
    if (done) done_cnt++;
    if (bus.p_programm_o) prog_seen = 1;
  end

  // Simple control-unit model: follows p_programm_o with a configurable delay.
  bit cu_auto  = 0;
  int cu_delay = 3;
  int cu_cnt   = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cu_auto) begin
        if (bus.p_programm_o) begin
          if (cu_cnt >= cu_delay) bus.p_active_i = 1'b1;
          else cu_cnt++;
        end else begin
          bus.p_active_i = 1'b0;
          cu_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    tick(1);
    bus.rx_valid_i = 1'b0;
    tick(gap);
  endtask

  task automatic wait_active();
    for (int k = 0; k < 40 && !bus.p_active_i; k++) tick(1);
    chk("p_active rise", 32'(bus.p_active_i), 32'd1);
  endtask

  // Session driven from sq; expectations come from eq / exp_err / exp_prog.
  logic [7:0] sq [$];
  logic [7:0] eq [$];

  task automatic run_session(input string nm, input bit exp_err, input bit exp_prog, input bit rnd_gap);
    int d0;
    wlog.delete();
    prog_seen = 0;
    d0 = done_cnt;
    foreach (sq[i]) begin
      send(sq[i], rnd_gap ? int'($urandom_range(0, 2)) : 1);
      if (i == 1 && exp_prog) wait_active();
    end
    for (int k = 0; k < 200 && done_cnt == d0; k++) tick(1);
    tick(2);
    chk({nm, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, " write count"}, 32'(wlog.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < wlog.size(); i++)
      chk($sformatf("%s write %0d", nm, i), 32'(wlog[i]), 32'(eq[i]));
    chk({nm, " error"}, 32'(error), 32'(exp_err));
    chk({nm, " programm seen"}, 32'(prog_seen), 32'(exp_prog));
    chk({nm, " busy after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    string      nm;
    logic [7:0] b [6];
    int         n;
    logic [7:0] w [2];
    int         nw;
    bit         err;
    bit         prog;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int         c;
    int         r;
    logic [7:0] cs;
    logic [7:0] v;
    bit         bad;

    tbl[0] = '{"nominal",  '{8'hA5, 8'h02, 8'h3C, 8'h7F, 8'h43, 8'h00}, 5, '{8'h3C, 8'h7F}, 2, 1'b0, 1'b1};
    tbl[1] = '{"mismatch", '{8'hA5, 8'h01, 8'h25, 8'h00, 8'h00, 8'h00}, 4, '{8'h25, 8'h00}, 1, 1'b1, 1'b1};
    tbl[2] = '{"sync data",'{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00}, 4, '{8'hA5, 8'h00}, 1, 1'b0, 1'b1};
    tbl[3] = '{"count 17", '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00}, 2, '{8'h00, 8'h00}, 0, 1'b1, 1'b0};
    tbl[4] = '{"count 0",  '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, '{8'h00, 8'h00}, 0, 1'b1, 1'b0};

    reset_n        = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.p_active_i = 1'b0;
    #1;
    chk("reset programm", 32'(bus.p_programm_o), 32'd0);
    chk("reset we", 32'(bus.p_write_en_mem_o), 32'd0);
    chk("reset addr/data", 32'({bus.p_address_o, bus.p_data_o}), 32'd0);
    chk("reset busy/done/error", 32'({busy, done, error}), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    send(8'h12, 1);
    send(8'h34, 1);
    chk("idle junk busy", 32'(busy), 32'd0);
    chk("idle junk writes", 32'(wlog.size()), 32'd0);

    cu_auto  = 1;
    cu_delay = 3;
    foreach (tbl[t]) begin
      sq.delete();
      eq.delete();
      for (int i = 0; i < tbl[t].n; i++) sq.push_back(tbl[t].b[i]);
      for (int i = 0; i < tbl[t].nw; i++) eq.push_back(tbl[t].w[i]);
      run_session(tbl[t].nm, tbl[t].err, tbl[t].prog, 1'b0);
    end

    // Error from the bad count above is cleared by the next accepted sync byte.
    send(8'hA5, 1);
    chk("sync clears error", 32'(error), 32'd0);
    chk("busy after sync", 32'(busy), 32'd1);
    send(8'h00, 2);
    chk("bad count again", 32'(error), 32'd1);

    // Overrun with the control unit held inactive.
    cu_auto = 0;
    bus.p_active_i = 1'b0;
    tick(2);
    wlog.delete();
    r = done_cnt;
    send(8'hA5, 1);
    send(8'h02, 1);
    send(8'h11, 0);
    send(8'h22, 1);
    send(8'h33, 1);
    chk("overrun error", 32'(error), 32'd1);
    chk("overrun no write yet", 32'(wlog.size()), 32'd0);
    chk("overrun programm held", 32'(bus.p_programm_o), 32'd1);
    bus.p_active_i = 1'b1;
    tick(3);
    chk("overrun write count", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) chk("overrun write", 32'(wlog[0]), 32'h11);
    chk("overrun programm drop", 32'(bus.p_programm_o), 32'd0);
    bus.p_active_i = 1'b0;
    tick(3);
    chk("overrun done", 32'(done_cnt - r), 32'd1);
    chk("overrun busy", 32'(busy), 32'd0);

    // Reset in the middle of a record phase.
    bus.p_active_i = 1'b0;
    wlog.delete();
    send(8'hA5, 1);
    send(8'h02, 1);
    send(8'h3C, 1);
    chk("pre-reset programm", 32'(bus.p_programm_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid reset programm", 32'(bus.p_programm_o), 32'd0);
    chk("mid reset we", 32'(bus.p_write_en_mem_o), 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    #1;
    bus.p_active_i = 1'b1;
    tick(3);
    chk("no write in reset", 32'(wlog.size()), 32'd0);
    bus.p_active_i = 1'b0;
    reset_n = 1'b1;
    tick(2);
    chk("no write after reset", 32'(wlog.size()), 32'd0);
    cu_auto = 1;

    // Random sessions checked against the frame rules.
    for (int s = 0; s < 30; s++) begin
      cu_delay = $urandom_range(0, 4);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        v = 8'($urandom);
        if (v == 8'hA5) v = 8'h5A;
        send(v, 1);
      end
      r = $urandom_range(0, 9);
      c = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(17, 255)) : int'($urandom_range(1, 16));
      sq.delete();
      eq.delete();
      sq.push_back(8'hA5);
      sq.push_back(8'(c));
      bad = 0;
      if (c >= 1 && c <= 16) begin
        cs = 8'h00;
        for (int i = 0; i < c; i++) begin
          v = 8'($urandom);
          sq.push_back(v);
          eq.push_back(v);
          cs ^= v;
        end
        if ($urandom_range(0, 3) == 0) begin
          cs ^= 8'($urandom_range(1, 255));
          bad = 1;
        end
        sq.push_back(cs);
        run_session($sformatf("rand%0d", s), bad, 1'b1, 1'b1);
      end else begin
        run_session($sformatf("rand%0d badcnt", s), 1'b1, 1'b0, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
